// File: rtl/count_readout.sv
// Readout stage behind the coincidence detector: snapshots the counters when the
// acquisition window closes, streams them as a valid/ready frame, then requests a restart.
module count_readout #(
   parameter  int unsigned NCHAN  = 4,
   parameter  int unsigned NBITS  = 4,
   parameter  int unsigned FBITS  = 8,
   localparam int unsigned NPAIRS = NCHAN * (NCHAN - 1) / 2,
   localparam int unsigned NWORDS = 1 + NCHAN + NPAIRS,
   localparam int unsigned IBITS  = $clog2(NWORDS)
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Enable_i,
   input  logic [NBITS-1:0] nCycles_i,
   input  logic [NBITS-1:0] Cnt_Clk,
   input  logic [NBITS-1:0] Cnt_chann [NCHAN],
   input  logic [NBITS-1:0] Cnt_pairs [NPAIRS],
   output logic [NBITS-1:0] Data_o,
   output logic [IBITS-1:0] Index_o,
   output logic             Valid_o,
   input  logic             Ready_i,
   output logic             Last_o,
   output logic [FBITS-1:0] Frame_o,
   output logic             Restart_o,
   output logic             Busy_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_SEND,
      S_RESTART
   } state_t;

   state_t           state_q, state_d;
   logic [NBITS-1:0] snap_q [NWORDS];
   logic [NBITS-1:0] snap_d [NWORDS];
   logic [NBITS-1:0] data_q, data_d;
   logic [IBITS-1:0] index_q, index_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic [FBITS-1:0] frame_q, frame_d;
   logic             restart_q, restart_d;
   logic             busy_q, busy_d;

   logic             done_c;
   logic [IBITS-1:0] next_idx_c;

   assign done_c     = Enable_i && (Cnt_Clk == nCycles_i);
   assign next_idx_c = index_q + IBITS'(1);

   // Next-state and registered-output logic; live counters are only read in ARMED/RESTART.
   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      data_d    = data_q;
      index_d   = index_q;
      valid_d   = valid_q;
      last_d    = last_q;
      frame_d   = frame_q;
      restart_d = restart_q;
      busy_d    = busy_q;

      case (state_q)
         S_IDLE: begin
            if (Enable_i) begin
               state_d = S_ARMED;
            end
         end

         S_ARMED: begin
            if (!Enable_i) begin
               state_d = S_IDLE;
            end else if (done_c) begin
               snap_d[0] = Cnt_Clk;
               for (int unsigned i = 0; i < NCHAN; i++) begin
                  snap_d[1 + i] = Cnt_chann[i];
               end
               for (int unsigned p = 0; p < NPAIRS; p++) begin
                  snap_d[1 + NCHAN + p] = Cnt_pairs[p];
               end
               data_d  = Cnt_Clk;
               index_d = '0;
               last_d  = (NWORDS == 1);
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = S_SEND;
            end
         end

         S_SEND: begin
            if (valid_q && Ready_i) begin
               if (last_q) begin
                  valid_d   = 1'b0;
                  last_d    = 1'b0;
                  frame_d   = frame_q + FBITS'(1);
                  restart_d = 1'b1;
                  state_d   = S_RESTART;
               end else begin
                  index_d = next_idx_c;
                  data_d  = snap_q[next_idx_c];
                  last_d  = (next_idx_c == IBITS'(NWORDS - 1));
               end
            end
         end

         S_RESTART: begin
            // Hold the restart request until the detector shows a cleared clock counter.
            if (Cnt_Clk == '0) begin
               restart_d = 1'b0;
               busy_d    = 1'b0;
               state_d   = Enable_i ? S_ARMED : S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= S_IDLE;
         data_q    <= '0;
         index_q   <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         frame_q   <= '0;
         restart_q <= 1'b0;
         busy_q    <= 1'b0;
         for (int unsigned w = 0; w < NWORDS; w++) begin
            snap_q[w] <= '0;
         end
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         index_q   <= index_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         frame_q   <= frame_d;
         restart_q <= restart_d;
         busy_q    <= busy_d;
         for (int unsigned w = 0; w < NWORDS; w++) begin
            snap_q[w] <= snap_d[w];
         end
      end
   end

   assign Data_o    = data_q;
   assign Index_o   = index_q;
   assign Valid_o   = valid_q;
   assign Last_o    = last_q;
   assign Frame_o   = frame_q;
   assign Restart_o = restart_q;
   assign Busy_o    = busy_q;

endmodule

// File: tb/tb_count_readout.sv
// Scoreboard bench for count_readout: expected words are queued by the driver and
// checked by an independent monitor whenever the DUT presents a valid word.
module tb_count_readout;

   localparam int unsigned NCHAN  = 4;
   localparam int unsigned NBITS  = 4;
   localparam int unsigned FBITS  = 2;
   localparam int unsigned NPAIRS = 6;
   localparam int unsigned NWORDS = 11;

   typedef struct packed {
      logic [3:0] data;
      logic [3:0] idx;
      logic       last;
      logic [1:0] frame;
   } word_t;

   logic             Clk;
   logic             Rst_n;
   logic             Enable_i;
   logic [NBITS-1:0] nCycles_i;
   logic [NBITS-1:0] Cnt_Clk;
   logic [NBITS-1:0] ch_live [NCHAN];
   logic [NBITS-1:0] pr_live [NPAIRS];
   logic [NBITS-1:0] Data_o;
   logic [3:0]       Index_o;
   logic             Valid_o;
   logic             Ready_i;
   logic             Last_o;
   logic [FBITS-1:0] Frame_o;
   logic             Restart_o;
   logic             Busy_o;

   int         checks   = 0;
   int         failures = 0;
   word_t      sb [$];
   logic [3:0] vec [NWORDS];
   logic [1:0] exp_frame;

   count_readout #(.NCHAN(NCHAN), .NBITS(NBITS), .FBITS(FBITS)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .Enable_i  (Enable_i),
      .nCycles_i (nCycles_i),
      .Cnt_Clk   (Cnt_Clk),
      .Cnt_chann (ch_live),
      .Cnt_pairs (pr_live),
      .Data_o    (Data_o),
      .Index_o   (Index_o),
      .Valid_o   (Valid_o),
      .Ready_i   (Ready_i),
      .Last_o    (Last_o),
      .Frame_o   (Frame_o),
      .Restart_o (Restart_o),
      .Busy_o    (Busy_o)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [1:0] f);
      for (int i = 0; i < int'(NWORDS); i++) begin
         sb.push_back(word_t'{data: vec[i], idx: 4'(i), last: (i == int'(NWORDS) - 1), frame: f});
      end
   endtask

   task automatic do_reset();
      Rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(Valid_o), 32'd0);
      chk("rst_restart", 32'(Restart_o), 32'd0);
      chk("rst_frame", 32'(Frame_o), 32'd0);
      chk("rst_busy", 32'(Busy_o), 32'd0);
      sb.delete();
      exp_frame = 2'd0;
      Enable_i  = 1'b0;
      Cnt_Clk   = '0;
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
   endtask

   // One window using vec[] as the detector's final counts; live counters are scrambled after the snapshot.
   task automatic run_frame(input bit toggle, input int drop_en_at, input int rst_at_idx);
      int vcnt;
      bit got_restart;
      nCycles_i = vec[0];
      Cnt_Clk   = vec[0] - 4'd1;
      for (int i = 0; i < int'(NCHAN); i++) ch_live[i] = vec[1 + i];
      for (int p = 0; p < int'(NPAIRS); p++) pr_live[p] = vec[1 + NCHAN + p];
      Enable_i = 1'b1;
      Ready_i  = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      chk("armed_no_valid", 32'(Valid_o), 32'd0);
      push_frame(exp_frame);
      Cnt_Clk = vec[0];
      @(posedge Clk);
      #1;
      chk("latency1_valid", 32'(Valid_o), 32'd1);
      chk("snap_busy", 32'(Busy_o), 32'd1);
      Cnt_Clk = '0;
      for (int i = 0; i < int'(NCHAN); i++) ch_live[i] = ~ch_live[i];
      for (int p = 0; p < int'(NPAIRS); p++) pr_live[p] = pr_live[p] + 4'd7;
      Ready_i     = 1'b1;
      vcnt        = 1;
      got_restart = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge Clk);
         #1;
         if (rst_at_idx >= 0 && Valid_o && int'(Index_o) == rst_at_idx) begin
            do_reset();
            return;
         end
         if (c == drop_en_at) Enable_i = 1'b0;
         if (Restart_o) begin
            got_restart = 1'b1;
            break;
         end
         if (Valid_o) vcnt++;
         if (toggle) Ready_i = ~Ready_i;
      end
      chk("restart_seen", 32'(got_restart), 32'd1);
      chk("frame_cycles", 32'(vcnt), toggle ? 32'd21 : 32'd11);
      chk("valid_low_in_restart", 32'(Valid_o), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      exp_frame = exp_frame + 2'd1;
      chk("frame_incr", 32'(Frame_o), 32'(exp_frame));
      Ready_i = 1'b1;
      @(posedge Clk);
      #1;
      chk("restart_1cyc", 32'(Restart_o), 32'd0);
      chk("busy_clear", 32'(Busy_o), 32'd0);
   endtask

   // Back-to-back frames with nCycles_i == 0 and a cleared detector.
   task automatic run_zero(input int k);
      int  pulses;
      int  rhigh;
      bit  prev;
      for (int i = 0; i < int'(NWORDS); i++) vec[i] = 4'd0;
      for (int j = 0; j < k; j++) push_frame(exp_frame + 2'(j));
      nCycles_i = '0;
      Cnt_Clk   = '0;
      for (int i = 0; i < int'(NCHAN); i++) ch_live[i] = '0;
      for (int p = 0; p < int'(NPAIRS); p++) pr_live[p] = '0;
      Ready_i  = 1'b1;
      Enable_i = 1'b1;
      pulses   = 0;
      rhigh    = 0;
      prev     = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge Clk);
         #1;
         if (Restart_o) begin
            rhigh++;
            if (!prev) begin
               pulses++;
               if (pulses == k) Enable_i = 1'b0;
            end
         end
         prev = Restart_o;
         if (pulses == k && !Restart_o) break;
      end
      chk("zero_pulses", 32'(pulses), 32'(k));
      chk("zero_restart_cycles", 32'(rhigh), 32'(k));
      chk("zero_sb_drained", 32'(sb.size()), 32'd0);
      exp_frame = exp_frame + 2'(k);
      chk("zero_frame", 32'(Frame_o), 32'(exp_frame));
      chk("zero_idle_busy", 32'(Busy_o), 32'd0);
   endtask

   // Monitor: every presented word must match the head of the scoreboard; pop on acceptance.
   initial begin
      word_t w;
      forever begin
         @(negedge Clk);
         if (Rst_n && Valid_o) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_word: got data=%0d idx=%0d expected none at %0t",
                        Data_o, Index_o, $time);
            end else begin
               w = word_t'{data: Data_o, idx: Index_o, last: Last_o, frame: Frame_o};
               chk("word", 32'(w), 32'(sb[0]));
               if (Ready_i) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Rst_n     = 1'b0;
      Enable_i  = 1'b0;
      nCycles_i = '0;
      Cnt_Clk   = '0;
      Ready_i   = 1'b0;
      exp_frame = 2'd0;
      for (int i = 0; i < int'(NCHAN); i++) ch_live[i] = '0;
      for (int p = 0; p < int'(NPAIRS); p++) pr_live[p] = '0;
      repeat (2) @(posedge Clk);
      #1;
      chk("reset_valid", 32'(Valid_o), 32'd0);
      chk("reset_data", 32'(Data_o), 32'd0);
      chk("reset_index", 32'(Index_o), 32'd0);
      chk("reset_last", 32'(Last_o), 32'd0);
      chk("reset_frame", 32'(Frame_o), 32'd0);
      chk("reset_restart", 32'(Restart_o), 32'd0);
      chk("reset_busy", 32'(Busy_o), 32'd0);
      Rst_n = 1'b1;

      // T1 / T4: full-rate frame, words 5,3,1,0,2,1,0,0,0,1,0
      vec = '{4'd5, 4'd3, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
      run_frame(1'b0, -1, -1);

      // T2: same frame with Ready_i alternating
      run_frame(1'b1, -1, -1);

      // T3a: enable drops while armed, then the window closes with enable low
      Enable_i  = 1'b1;
      nCycles_i = 4'd5;
      Cnt_Clk   = 4'd2;
      repeat (3) @(posedge Clk);
      #1;
      chk("armed_busy", 32'(Busy_o), 32'd0);
      Enable_i = 1'b0;
      Cnt_Clk  = 4'd5;
      repeat (3) begin
         @(posedge Clk);
         #1;
         chk("disabled_no_valid", 32'(Valid_o), 32'd0);
         chk("disabled_no_restart", 32'(Restart_o), 32'd0);
      end

      // T3b: enable drops mid-frame, frame must still complete
      vec = '{4'd9, 4'd15, 4'd14, 4'd7, 4'd8, 4'd12, 4'd3, 4'd6, 4'd10, 4'd11, 4'd13};
      run_frame(1'b0, 3, -1);

      // T5: reset while word 4 is presented, then a fresh frame starts at frame 0
      vec = '{4'd6, 4'd2, 4'd4, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11};
      run_frame(1'b0, -1, 4);
      chk("post_reset_frame", 32'(Frame_o), 32'd0);
      vec = '{4'd3, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
      run_frame(1'b0, -1, -1);

      // T6: frame counter wraps after four frames
      do_reset();
      for (int j = 0; j < 5; j++) begin
         for (int i = 0; i < int'(NWORDS); i++) vec[i] = 4'(i + j + 2);
         run_frame(j[0], -1, -1);
      end
      chk("frame_wrapped", 32'(Frame_o), 32'd1);

      // T6: nCycles_i == 0 gives continuous all-zero frames
      run_zero(3);

      repeat (3) @(posedge Clk);
      #1;
      chk("end_no_valid", 32'(Valid_o), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
